context_exchange_sequencer: RTL and testbench

Consumer end of the context-exchange handshake. Detects each LOAD_CXC request from the context exchange controller and decodes the CXC_REGISTER reason code. Saves the preempted process's resume PC and updates its status. Selects the next READY process round-robin and issues a one-cycle PC load to the fetch stage; when no process is READY, it redirects to the operating-system menu.

---
 rtl/context_exchange_sequencer_pkg.sv | 33 +++
 rtl/context_exchange_sequencer_rr_ready_picker.sv | 32 +++
 rtl/context_exchange_sequencer.sv | 141 ++++++++++++++
 tb/tb_context_exchange_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/context_exchange_sequencer_pkg.sv
// Shared encodings for the context-exchange handshake (controller and sequencer side).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package context_exchange_sequencer_pkg;

   // Per-process scheduling status, two bits per slot in the packed status vector
   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_READY   = 2'd1,
      ST_WAITING = 2'd2,
      ST_HALTED  = 2'd3
   } proc_status_t;

   // Reason code carried in CXC_REGISTER[1:0]
   typedef enum logic [1:0] {
      CXC_DISABLED = 2'd0,
      CXC_CHANGE   = 2'd1,
      CXC_WAIT     = 2'd2,
      CXC_HALT     = 2'd3
   } cxc_code_t;

   // Sequencer states
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_SAVE     = 2'd1,
      S_SELECT   = 2'd2,
      S_DISPATCH = 2'd3
   } seq_state_t;

   // Fetch address of the operating-system menu, used when nothing is READY
   localparam int OS_MENU_ADDRESS = 512;

endpackage

// File: rtl/context_exchange_sequencer_rr_ready_picker.sv
// Round-robin finder: first READY slot scanning start+1, start+2, ..., start (wrapping).
// Latency: purely combinational.
// Backpressure: none; o_valid low when no slot is READY.
module rr_ready_picker
   import context_exchange_sequencer_pkg::*;
#(
   parameter int NUM_PROCESSES = 4,
   parameter int PID_WIDTH     = 2
) (
   input  logic [2*NUM_PROCESSES-1:0] i_status,
   input  logic [PID_WIDTH-1:0]       i_start_pid,
   output logic                       o_valid,
   output logic [PID_WIDTH-1:0]       o_pid
);

   logic [PID_WIDTH-1:0] w_idx;

   // Walk the ring once starting after the current owner; the owner itself is checked last
   always_comb begin
      o_valid = 1'b0;
      o_pid   = i_start_pid;
      w_idx   = i_start_pid;
      for (int i = 1; i <= NUM_PROCESSES; i++) begin
         w_idx = i_start_pid + PID_WIDTH'(i);
         if (!o_valid && (i_status[{w_idx, 1'b0} +: 2] == ST_READY)) begin
            o_valid = 1'b1;
            o_pid   = w_idx;
         end
      end
   end

endmodule

// File: rtl/context_exchange_sequencer.sv
// Context-exchange consumer: saves preempted PC/status, picks next READY process, strobes PC load.
// Latency: PC_LOAD in the 3rd cycle after the LOAD_CXC rising edge is sampled in IDLE.
// Backpressure: none; requests arriving while BUSY are dropped, creates only accepted in IDLE.
module context_exchange_sequencer
   import context_exchange_sequencer_pkg::*;
#(
   parameter int NUM_PROCESSES      = 4,
   parameter int PID_WIDTH          = 2,
   parameter int INSTMEM_ADDR_WIDTH = 13,
   parameter int DATA_WIDTH         = 32
) (
   input  logic                          i_wclock,
   input  logic                          i_reset,
   input  logic                          i_load_cxc,
   input  logic [DATA_WIDTH-1:0]         i_cxc_register,
   input  logic [INSTMEM_ADDR_WIDTH-1:0] i_pc,
   input  logic                          i_process_create,
   input  logic [PID_WIDTH-1:0]          i_create_pid,
   input  logic [INSTMEM_ADDR_WIDTH-1:0] i_create_pc,
   input  logic                          i_io_done,
   input  logic [PID_WIDTH-1:0]          i_io_done_pid,
   output logic [PID_WIDTH-1:0]          o_current_pid,
   output logic [INSTMEM_ADDR_WIDTH-1:0] o_next_pc,
   output logic                          o_pc_load,
   output logic                          o_os_return,
   output logic                          o_busy,
   output logic [2*NUM_PROCESSES-1:0]    o_process_status
);

   localparam logic [INSTMEM_ADDR_WIDTH-1:0] LP_OS_MENU_PC = INSTMEM_ADDR_WIDTH'(OS_MENU_ADDRESS);

   seq_state_t                    r_state;
   seq_state_t                    w_state_nxt;
   logic                          r_load_cxc_d;
   logic [INSTMEM_ADDR_WIDTH-1:0] r_cap_pc;
   cxc_code_t                     r_code;
   logic [PID_WIDTH-1:0]          r_cur_pid;
   logic [INSTMEM_ADDR_WIDTH-1:0] r_next_pc;
   logic                          r_os_flag;
   logic [2*NUM_PROCESSES-1:0]    r_status;
   logic [INSTMEM_ADDR_WIDTH-1:0] r_pc_table [NUM_PROCESSES];

   logic                          w_detect;
   logic                          w_code_ok;
   proc_status_t                  w_save_status;
   logic                          w_pick_vld;
   logic [PID_WIDTH-1:0]          w_pick_pid;

   assign w_detect  = (r_state == S_IDLE) && i_load_cxc && !r_load_cxc_d;
   assign w_code_ok = (i_cxc_register[1:0] != 2'b00) && (i_cxc_register[DATA_WIDTH-1:2] == '0);

   rr_ready_picker #(
      .NUM_PROCESSES (NUM_PROCESSES),
      .PID_WIDTH     (PID_WIDTH)
   ) u_picker (
      .i_status    (r_status),
      .i_start_pid (r_cur_pid),
      .o_valid     (w_pick_vld),
      .o_pid       (w_pick_pid)
   );

   // Status written back for the preempted process; a same-cycle I/O completion wins over WAITING
   always_comb begin
      w_save_status = ST_READY;
      case (r_code)
         CXC_WAIT: w_save_status = (i_io_done && (i_io_done_pid == r_cur_pid)) ? ST_READY : ST_WAITING;
         CXC_HALT: w_save_status = ST_HALTED;
         default:  w_save_status = ST_READY;
      endcase
   end

   // State register
   always_ff @(posedge i_wclock) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next state and strobe outputs; an invalid reason code bails out of SAVE untouched
   always_comb begin
      w_state_nxt = r_state;
      o_pc_load   = 1'b0;
      o_os_return = 1'b0;
      o_busy      = (r_state != S_IDLE);
      case (r_state)
         S_IDLE:     if (w_detect) w_state_nxt = S_SAVE;
         S_SAVE:     w_state_nxt = (r_code == CXC_DISABLED) ? S_IDLE : S_SELECT;
         S_SELECT:   w_state_nxt = S_DISPATCH;
         S_DISPATCH: begin
            w_state_nxt = S_IDLE;
            o_pc_load   = 1'b1;
            o_os_return = r_os_flag;
         end
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Process tables, request capture and selection; later writes take priority over earlier ones
   always_ff @(posedge i_wclock) begin
      if (i_reset) begin
         r_load_cxc_d <= 1'b0;
         r_cap_pc     <= '0;
         r_code       <= CXC_DISABLED;
         r_cur_pid    <= '0;
         r_next_pc    <= '0;
         r_os_flag    <= 1'b0;
         r_status     <= '0;
         for (int i = 0; i < NUM_PROCESSES; i++) r_pc_table[i] <= '0;
      end else begin
         r_load_cxc_d <= i_load_cxc;
         if (w_detect) begin
            r_cap_pc <= i_pc;
            r_code   <= w_code_ok ? cxc_code_t'(i_cxc_register[1:0]) : CXC_DISABLED;
         end
         if (i_io_done && (r_status[{i_io_done_pid, 1'b0} +: 2] == ST_WAITING))
            r_status[{i_io_done_pid, 1'b0} +: 2] <= ST_READY;
         if ((r_state == S_IDLE) && i_process_create) begin
            r_pc_table[i_create_pid]            <= i_create_pc;
            r_status[{i_create_pid, 1'b0} +: 2] <= ST_READY;
         end
         if ((r_state == S_SAVE) && (r_code != CXC_DISABLED)) begin
            r_pc_table[r_cur_pid]            <= r_cap_pc;
            r_status[{r_cur_pid, 1'b0} +: 2] <= w_save_status;
         end
         if (r_state == S_SELECT) begin
            if (w_pick_vld) begin
               r_cur_pid <= w_pick_pid;
               r_next_pc <= r_pc_table[w_pick_pid];
               r_os_flag <= 1'b0;
            end else begin
               r_next_pc <= LP_OS_MENU_PC;
               r_os_flag <= 1'b1;
            end
         end
      end
   end

   assign o_current_pid    = r_cur_pid;
   assign o_next_pc        = r_next_pc;
   assign o_process_status = r_status;

endmodule

// File: tb/tb_context_exchange_sequencer.sv
// Bench for context_exchange_sequencer: directed scenarios plus randomized traffic.
// Latency: outputs compared each cycle against a transaction-level model.
// Backpressure: n/a.
module tb_context_exchange_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_cxc = 1'b0;
   logic [31:0] cxc = 32'd0;
   logic [12:0] pc = 13'd0;
   logic        create = 1'b0;
   logic [1:0]  create_pid = 2'd0;
   logic [12:0] create_pc = 13'd0;
   logic        io_done = 1'b0;
   logic [1:0]  io_pid = 2'd0;

   logic [1:0]  o_current_pid;
   logic [12:0] o_next_pc;
   logic        o_pc_load;
   logic        o_os_return;
   logic        o_busy;
   logic [7:0]  o_process_status;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   context_exchange_sequencer dut (
      .i_wclock         (clk),
      .i_reset          (rst),
      .i_load_cxc       (load_cxc),
      .i_cxc_register   (cxc),
      .i_pc             (pc),
      .i_process_create (create),
      .i_create_pid     (create_pid),
      .i_create_pc      (create_pc),
      .i_io_done        (io_done),
      .i_io_done_pid    (io_pid),
      .o_current_pid    (o_current_pid),
      .o_next_pc        (o_next_pc),
      .o_pc_load        (o_pc_load),
      .o_os_return      (o_os_return),
      .o_busy           (o_busy),
      .o_process_status (o_process_status)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_age counts cycles since an accepted request: 0 = no sequence in progress,
   // 1 = saving, 2 = choosing, 3 = load strobe cycle.
   logic [1:0]  m_status [4];
   logic [12:0] m_pc [4];
   logic [1:0]  m_cur;
   logic [12:0] m_next;
   logic        m_prev_load;
   int          m_age;
   logic [1:0]  m_code;
   logic        m_code_ok;
   logic [12:0] m_cap;
   logic        m_osret;

   task automatic model_step();
      logic [1:0] old [4];
      bit found;
      int s;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin m_status[i] = 2'd0; m_pc[i] = 13'd0; end
         m_cur = 2'd0; m_next = 13'd0; m_prev_load = 1'b0; m_age = 0;
         m_code = 2'd0; m_code_ok = 1'b0; m_cap = 13'd0; m_osret = 1'b0;
         return;
      end
      old = m_status;
      if (io_done && old[io_pid] == 2'd2) m_status[io_pid] = 2'd1;
      if (m_age == 0 && create) begin
         m_status[create_pid] = 2'd1;
         m_pc[create_pid]     = create_pc;
      end
      if (m_age == 1 && m_code_ok) begin
         m_pc[m_cur] = m_cap;
         if (m_code == 2'd1)      m_status[m_cur] = 2'd1;
         else if (m_code == 2'd3) m_status[m_cur] = 2'd3;
         else                     m_status[m_cur] = (io_done && io_pid == m_cur) ? 2'd1 : 2'd2;
      end
      if (m_age == 2) begin
         found = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            s = (int'(m_cur) + k) % 4;
            if (!found && old[s] == 2'd1) begin
               found = 1'b1;
               m_cur = 2'(s);
            end
         end
         m_next  = found ? m_pc[m_cur] : 13'd512;
         m_osret = !found;
      end
      if (m_age == 0) begin
         if (load_cxc && !m_prev_load) begin
            m_age     = 1;
            m_cap     = pc;
            m_code    = cxc[1:0];
            m_code_ok = (cxc[1:0] != 2'd0) && (cxc[31:2] == 30'd0);
         end
      end else if (m_age == 1) m_age = m_code_ok ? 2 : 0;
      else if (m_age == 2)     m_age = 3;
      else                     m_age = 0;
      m_prev_load = load_cxc;
   endtask

   always @(posedge clk) model_step();

   // Single compare process: every cycle, all outputs against the model
   always @(negedge clk) begin
      logic [7:0] exp_st;
      for (int i = 0; i < 4; i++) exp_st[2*i +: 2] = m_status[i];
      chk("cyc_status",    32'(o_process_status), 32'(exp_st));
      chk("cyc_pid",       32'(o_current_pid),    32'(m_cur));
      chk("cyc_next_pc",   32'(o_next_pc),        32'(m_next));
      chk("cyc_pc_load",   32'(o_pc_load),        32'(m_age == 3));
      chk("cyc_os_return", 32'(o_os_return),      32'(m_age == 3 && m_osret));
      chk("cyc_busy",      32'(o_busy),           32'(m_age != 0));
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic do_create(input logic [1:0] pid, input logic [12:0] cpc);
      create = 1'b1; create_pid = pid; create_pc = cpc;
      step();
      create = 1'b0;
   endtask

   // One-cycle LOAD_CXC pulse; optional I/O completion during the save cycle.
   // Observes 8 cycles: first cycle with PC_LOAD (1 = detect cycle), number of loads, OS_RETURN at load.
   task automatic request(input logic [31:0] code, input logic [12:0] pcv, input int io_in_save,
                          output int first, output int loads, output logic osr);
      load_cxc = 1'b1; cxc = code; pc = pcv;
      first = 0; loads = 0; osr = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (o_pc_load) begin
            loads++;
            if (first == 0) first = c;
            osr = o_os_return;
         end
         if (c == 1) begin
            load_cxc = 1'b0;
            if (io_in_save >= 0) begin io_done = 1'b1; io_pid = 2'(io_in_save); end
         end else io_done = 1'b0;
      end
   endtask

   int   first, loads;
   logic osr;

   initial begin
      // Reset state
      step(); step();
      rst = 1'b0;
      chk("reset_status",  32'(o_process_status), 32'h0);
      chk("reset_pid",     32'(o_current_pid),    32'h0);
      chk("reset_next_pc", 32'(o_next_pc),        32'h0);
      chk("reset_pc_load", 32'(o_pc_load),        32'h0);
      chk("reset_busy",    32'(o_busy),           32'h0);

      // CHANGE from PID0 to PID1
      do_create(2'd0, 13'h010);
      do_create(2'd1, 13'h100);
      request(32'd1, 13'h025, -1, first, loads, osr);
      chk("t1_latency", 32'(first), 32'd3);
      chk("t1_loads",   32'(loads), 32'd1);
      chk("t1_os_ret",  32'(osr),   32'd0);
      chk("t1_next_pc", 32'(o_next_pc), 32'h100);
      chk("t1_pid",     32'(o_current_pid), 32'd1);
      chk("t1_status0", 32'(o_process_status[1:0]), 32'd1);

      // WAIT from PID1 back to PID0, then I/O completion
      request(32'd2, 13'h130, -1, first, loads, osr);
      chk("t2_status1", 32'(o_process_status[3:2]), 32'd2);
      chk("t2_next_pc", 32'(o_next_pc), 32'h025);
      chk("t2_pid",     32'(o_current_pid), 32'd0);
      io_done = 1'b1; io_pid = 2'd1;
      step();
      io_done = 1'b0;
      chk("t2_io_ready", 32'(o_process_status[3:2]), 32'd1);

      // HALT of the only process -> OS menu
      rst = 1'b1; step(); rst = 1'b0;
      do_create(2'd0, 13'h040);
      request(32'd3, 13'h055, -1, first, loads, osr);
      chk("t3_status0", 32'(o_process_status[1:0]), 32'd3);
      chk("t3_loads",   32'(loads), 32'd1);
      chk("t3_os_ret",  32'(osr),   32'd1);
      chk("t3_next_pc", 32'(o_next_pc), 32'd512);
      chk("t3_pid",     32'(o_current_pid), 32'd0);

      // LOAD_CXC held 5 cycles, create while busy is dropped
      rst = 1'b1; step(); rst = 1'b0;
      do_create(2'd0, 13'h010);
      do_create(2'd1, 13'h100);
      load_cxc = 1'b1; cxc = 32'd1; pc = 13'h077;
      loads = 0;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (o_pc_load) loads++;
         if (c == 2) begin create = 1'b1; create_pid = 2'd2; create_pc = 13'h300; end
         if (c == 3) create = 1'b0;
         if (c == 5) load_cxc = 1'b0;
      end
      chk("t4_held_loads",  32'(loads), 32'd1);
      chk("t4_busy_create", 32'(o_process_status[5:4]), 32'd0);

      // WAIT with same-cycle I/O completion, then invalid codes
      do_create(2'd2, 13'h200);
      request(32'd1, 13'h111, -1, first, loads, osr);
      chk("t5_pid2",     32'(o_current_pid), 32'd2);
      chk("t5_next_pc2", 32'(o_next_pc), 32'h200);
      request(32'd2, 13'h222, 2, first, loads, osr);
      chk("t5_io_in_save", 32'(o_process_status[5:4]), 32'd1);
      chk("t5_status",     32'(o_process_status), 32'h15);
      chk("t5_pid0",       32'(o_current_pid), 32'd0);
      chk("t5_next_pc0",   32'(o_next_pc), 32'h077);
      request(32'd0, 13'h1AA, -1, first, loads, osr);
      chk("t5_inv0_loads",  32'(loads), 32'd0);
      chk("t5_inv0_status", 32'(o_process_status), 32'h15);
      chk("t5_inv0_next",   32'(o_next_pc), 32'h077);
      request(32'h5, 13'h1BB, -1, first, loads, osr);
      chk("t5_inv5_loads",  32'(loads), 32'd0);
      chk("t5_inv5_pid",    32'(o_current_pid), 32'd0);

      // Reset during SELECT aborts the sequence
      load_cxc = 1'b1; cxc = 32'd1; pc = 13'h0AB;
      step();
      load_cxc = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      loads = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (o_pc_load) loads++;
      end
      chk("t6_rst_loads",  32'(loads), 32'd0);
      chk("t6_rst_status", 32'(o_process_status), 32'h0);
      chk("t6_rst_pid",    32'(o_current_pid), 32'd0);
      chk("t6_rst_next",   32'(o_next_pc), 32'd0);

      // Randomized traffic, checked cycle by cycle against the model
      for (int n = 0; n < 4000; n++) begin
         int r;
         rst        = ($urandom_range(0, 599) == 0);
         load_cxc   = ($urandom_range(0, 3) == 0);
         r          = $urandom_range(0, 9);
         if (r == 0)      cxc = 32'd0;
         else if (r <= 3) cxc = 32'd1;
         else if (r <= 6) cxc = 32'd2;
         else if (r <= 8) cxc = 32'd3;
         else             cxc = ($urandom() << 2) | 32'($urandom_range(0, 3));
         pc         = 13'($urandom());
         create     = ($urandom_range(0, 6) == 0);
         create_pid = 2'($urandom());
         create_pc  = 13'($urandom());
         io_done    = ($urandom_range(0, 4) == 0);
         io_pid     = 2'($urandom());
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
